// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM states, direction type, flag bit positions and screen size.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    SCORED    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  typedef enum logic {
    POS = 1'b0,
    NEG = 1'b1
  } dir_t;

  localparam int EDGE_BOTTOM = 0;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_LEFT   = 3;

  localparam int COL_RX    = 0;
  localparam int COL_LX    = 1;
  localparam int COL_RY_LO = 2;
  localparam int COL_RY_HI = 4;
  localparam int COL_LY_LO = 5;
  localparam int COL_LY_HI = 7;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Modulo-2^32 step keeps ini+off correct for negative offsets.
  function automatic logic [31:0] step_offset(input logic [31:0] off, input dir_t dir,
                                              input logic [31:0] step);
    return (dir == POS) ? off + step : off - step;
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_score_keeper.sv
// Two saturating 4-bit player scores with synchronous clear and a win flag.
module ball_motion_ctrl_score_keeper #(
  parameter int WIN_SCORE = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc_l,
  input  logic       inc_r,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       win
);

  localparam logic [3:0] WIN_C = 4'(WIN_SCORE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_l <= 4'd0;
      score_r <= 4'd0;
    end else if (clr) begin
      score_l <= 4'd0;
      score_r <= 4'd0;
    end else begin
      if (inc_l && (score_l < WIN_C)) score_l <= score_l + 4'd1;
      if (inc_r && (score_r < WIN_C)) score_r <= score_r + 4'd1;
    end
  end

  assign win = (score_l == WIN_C) || (score_r == WIN_C);

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion, scoring, serve delay and game-over control for Pong.
// Optional macro BALL_SPEEDUP_EN: each paddle bounce raises step_x up to MAX_STEP_X.
//   state     | meaning
//   IDLE      | after reset, waiting for start
//   MOVE      | ball in play, offsets step on every frame_tick
//   SCORED    | point just scored, counting SERVE_DELAY frames before re-serve
//   GAME_OVER | a player reached WIN_SCORE, waiting for start
module ball_motion_ctrl
  import pong_pkg::*;
#(
  parameter int STEP_X      = 4,
  parameter int STEP_Y      = 2,
`ifdef BALL_SPEEDUP_EN
  parameter int MAX_STEP_X  = 12,
`endif
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [3:0]  ball_detect_edge,
  input  logic [7:0]  collision_detect,
  output logic [31:0] ball_off_x,
  output logic [31:0] ball_off_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over,
  output logic        in_play
);

  localparam int               CNT_W      = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [31:0]      STEP_Y_W   = 32'(STEP_Y);
  localparam logic [7:0]       STEP_X_C   = 8'(STEP_X);

  state_t           state, state_nxt;
  dir_t             dir_x, dir_x_nxt;
  dir_t             dir_y, dir_y_nxt;
  dir_t             serve_dir, serve_dir_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      off_x_nxt, off_y_nxt;
  logic             inc_l, inc_r, clr, win, point;
  logic             hit_r, hit_l;
  logic [7:0]       step_x;

  assign hit_r = collision_detect[COL_RX] & (|collision_detect[COL_RY_HI:COL_RY_LO]);
  assign hit_l = collision_detect[COL_LX] & (|collision_detect[COL_LY_HI:COL_LY_LO]);

`ifdef BALL_SPEEDUP_EN
  localparam logic [7:0] MAX_STEP_C = 8'(MAX_STEP_X);

  // dir_x only changes inside MOVE on an accepted bounce, so that marks a speed-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_x <= STEP_X_C;
    end else if ((state != MOVE) && (state_nxt == MOVE)) begin
      step_x <= STEP_X_C;
    end else if ((state == MOVE) && (dir_x_nxt != dir_x)) begin
      step_x <= (step_x >= MAX_STEP_C) ? MAX_STEP_C : step_x + 8'd1;
    end
  end
`else
  assign step_x = STEP_X_C;
`endif

  always_comb begin
    state_nxt     = state;
    dir_x_nxt     = dir_x;
    dir_y_nxt     = dir_y;
    serve_dir_nxt = serve_dir;
    cnt_nxt       = cnt;
    off_x_nxt     = ball_off_x;
    off_y_nxt     = ball_off_y;
    inc_l         = 1'b0;
    inc_r         = 1'b0;
    clr           = 1'b0;
    point         = 1'b0;
    case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_nxt = MOVE;
          off_x_nxt = 32'd0;
          off_y_nxt = 32'd0;
          dir_x_nxt = POS;
          dir_y_nxt = POS;
          clr       = 1'b1;
        end
      end
      MOVE: begin
        if (frame_tick) begin
          // Paddle hits outrank the same-side edge; direction tests block double bounces.
          if (hit_r && (dir_x == POS)) begin
            dir_x_nxt = NEG;
          end else if (hit_l && (dir_x == NEG)) begin
            dir_x_nxt = POS;
          end else if (!ball_detect_edge[EDGE_RIGHT]) begin
            inc_l         = 1'b1;
            serve_dir_nxt = POS;
            point         = 1'b1;
          end else if (!ball_detect_edge[EDGE_LEFT]) begin
            inc_r         = 1'b1;
            serve_dir_nxt = NEG;
            point         = 1'b1;
          end
          if (!ball_detect_edge[EDGE_BOTTOM] && (dir_y == POS)) begin
            dir_y_nxt = NEG;
          end else if (!ball_detect_edge[EDGE_TOP] && (dir_y == NEG)) begin
            dir_y_nxt = POS;
          end
          if (point) begin
            state_nxt = SCORED;
            cnt_nxt   = SERVE_LOAD;
          end else begin
            off_x_nxt = step_offset(ball_off_x, dir_x_nxt, 32'(step_x));
            off_y_nxt = step_offset(ball_off_y, dir_y_nxt, STEP_Y_W);
          end
        end
      end
      SCORED: begin
        if (frame_tick) begin
          if (cnt == '0) begin
            if (win) begin
              state_nxt = GAME_OVER;
            end else begin
              state_nxt = MOVE;
              off_x_nxt = 32'd0;
              off_y_nxt = 32'd0;
              dir_x_nxt = serve_dir;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir_x      <= POS;
      dir_y      <= POS;
      serve_dir  <= POS;
      cnt        <= '0;
      ball_off_x <= 32'd0;
      ball_off_y <= 32'd0;
      in_play    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir_x      <= dir_x_nxt;
      dir_y      <= dir_y_nxt;
      serve_dir  <= serve_dir_nxt;
      cnt        <= cnt_nxt;
      ball_off_x <= off_x_nxt;
      ball_off_y <= off_y_nxt;
      in_play    <= (state_nxt == MOVE);
      game_over  <= (state_nxt == GAME_OVER);
    end
  end

  ball_motion_ctrl_score_keeper #(
    .WIN_SCORE (WIN_SCORE)
  ) u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .inc_l   (inc_l),
    .inc_r   (inc_r),
    .score_l (score_l),
    .score_r (score_r),
    .win     (win)
  );

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: frame-level game model compared every cycle.
module tb_ball_motion_ctrl;

  localparam int MD_IDLE = 0;
  localparam int MD_PLAY = 1;
  localparam int MD_WAIT = 2;
  localparam int MD_OVER = 3;
  localparam int SX = 4;
  localparam int SY = 2;
  localparam int DELAY = 60;
  localparam int WIN = 9;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        start;
  logic [3:0]  edge_in;
  logic [7:0]  col;
  logic [31:0] ball_off_x, ball_off_y;
  logic [3:0]  score_l, score_r;
  logic        game_over, in_play;

  int n_pass = 0;
  int n_total = 0;

  ball_motion_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_tick       (frame_tick),
    .start            (start),
    .ball_detect_edge (edge_in),
    .collision_detect (col),
    .ball_off_x       (ball_off_x),
    .ball_off_y       (ball_off_y),
    .score_l          (score_l),
    .score_r          (score_r),
    .game_over        (game_over),
    .in_play          (in_play)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] offx;
    logic [31:0] offy;
    int          sl;
    int          sr;
    int          mode;
    int          frames_waited;
    bit          moving_right;
    bit          moving_down;
    bit          serve_right;
  } model_t;

  localparam model_t M_RESET = '{offx: 32'd0, offy: 32'd0, sl: 0, sr: 0, mode: MD_IDLE,
                                 frames_waited: 0, moving_right: 1'b1, moving_down: 1'b1,
                                 serve_right: 1'b1};

  model_t m;

  // One frame of game rules, applied to the whole game state at once.
  function automatic model_t game_step(input model_t cur, input bit tick, input bit st,
                                       input logic [3:0] e, input logic [7:0] c);
    model_t n = cur;
    bit right_paddle = c[0] && (c[4:2] != 3'b000);
    bit left_paddle  = c[1] && (c[7:5] != 3'b000);
    bit scored = 1'b0;
    if (cur.mode == MD_IDLE || cur.mode == MD_OVER) begin
      if (st) begin
        n = M_RESET;
        n.mode = MD_PLAY;
        n.serve_right = cur.serve_right;
      end
    end else if (cur.mode == MD_PLAY && tick) begin
      if (right_paddle && cur.moving_right) n.moving_right = 1'b0;
      else if (left_paddle && !cur.moving_right) n.moving_right = 1'b1;
      else if (!e[1]) begin
        if (cur.sl < WIN) n.sl = cur.sl + 1;
        n.serve_right = 1'b1;
        scored = 1'b1;
      end else if (!e[3]) begin
        if (cur.sr < WIN) n.sr = cur.sr + 1;
        n.serve_right = 1'b0;
        scored = 1'b1;
      end
      if (!e[0] && cur.moving_down) n.moving_down = 1'b0;
      else if (!e[2] && !cur.moving_down) n.moving_down = 1'b1;
      if (scored) begin
        n.mode = MD_WAIT;
        n.frames_waited = 0;
      end else begin
        n.offx = n.moving_right ? cur.offx + SX : cur.offx - SX;
        n.offy = n.moving_down ? cur.offy + SY : cur.offy - SY;
      end
    end else if (cur.mode == MD_WAIT && tick) begin
      n.frames_waited = cur.frames_waited + 1;
      if (n.frames_waited == DELAY) begin
        if (cur.sl == WIN || cur.sr == WIN) n.mode = MD_OVER;
        else begin
          n.mode = MD_PLAY;
          n.offx = 32'd0;
          n.offy = 32'd0;
          n.moving_right = cur.serve_right;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RESET;
    else m <= game_step(m, frame_tick, start, edge_in, col);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("off_x", ball_off_x, m.offx);
    check("off_y", ball_off_y, m.offy);
    check("score_l", {28'd0, score_l}, m.sl);
    check("score_r", {28'd0, score_r}, m.sr);
    check("game_over", {31'd0, game_over}, {31'd0, m.mode == MD_OVER});
    check("in_play", {31'd0, in_play}, {31'd0, m.mode == MD_PLAY});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [3:0] e, input logic [7:0] c);
    frame_tick = 1'b1;
    edge_in = e;
    col = c;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    edge_in = 4'hF;
    col = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    logic [7:0] c;
    rst_n = 1'b0;
    frame_tick = 1'b0;
    start = 1'b0;
    edge_in = 4'hF;
    col = 8'h00;
    idle(2);
    check("rst_off_x", ball_off_x, 32'd0);
    check("rst_in_play", {31'd0, in_play}, 32'd0);
    check("rst_game_over", {31'd0, game_over}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    pulse_start();
    check("start_in_play", {31'd0, in_play}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(4'hF, 8'h00);
      idle(1);
    end
    check("three_ticks_x", ball_off_x, 32'd12);
    check("three_ticks_y", ball_off_y, 32'd6);
    idle(2);
    check("hold_no_tick_x", ball_off_x, 32'd12);

    tick(4'b1110, 8'h00);
    tick(4'b1110, 8'h00);
    check("bottom_no_reflip_y", ball_off_y, 32'd2);

    tick(4'b1101, 8'b0000_0101);
    check("bounce_r_x", ball_off_x, 32'd16);
    check("bounce_r_no_point", {28'd0, score_l}, 32'd0);
    tick(4'hF, 8'b0010_0010);
    check("bounce_l_x", ball_off_x, 32'd20);

    tick(4'b1101, 8'h00);
    check("miss_right_score", {28'd0, score_l}, 32'd1);
    check("miss_right_x_held", ball_off_x, 32'd20);
    for (int i = 0; i < DELAY - 1; i++) tick(4'hF, 8'h00);
    check("delay_not_done", {31'd0, in_play}, 32'd0);
    tick(4'hF, 8'h00);
    check("serve_in_play", {31'd0, in_play}, 32'd1);
    check("serve_x_zero", ball_off_x, 32'd0);
    tick(4'hF, 8'h00);
    check("serve_dir_x", ball_off_x, 32'd4);
    check("neg_y_wrap", ball_off_y, 32'hFFFF_FFFE);

    for (int i = 0; i < 3000; i++) begin
      if (m.mode == MD_PLAY) tick(4'b0111, 8'h00);
      else if (m.mode == MD_WAIT) tick(4'hF, 8'h00);
      else break;
    end
    check("gameover_flag", {31'd0, game_over}, 32'd1);
    check("gameover_score_r", {28'd0, score_r}, 32'd9);
    check("gameover_score_l", {28'd0, score_l}, 32'd1);
    pulse_start();
    check("restart_score_r", {28'd0, score_r}, 32'd0);
    check("restart_in_play", {31'd0, in_play}, 32'd1);

    for (int f = 0; f < 600; f++) begin
      idle($urandom_range(0, 2));
      if ((m.mode == MD_IDLE || m.mode == MD_OVER) && ($urandom_range(0, 3) == 0)) pulse_start();
      e = 4'hF;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) e[b] = 1'b0;
      c = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      start = ($urandom_range(0, 9) == 0);
      tick(e, c);
      start = 1'b0;
    end

    for (int i = 0; i < 300; i++) begin
      if (m.mode == MD_PLAY) break;
      if (m.mode == MD_WAIT) tick(4'hF, 8'h00);
      else pulse_start();
    end
    tick(4'hF, 8'h00);
    tick(4'hF, 8'h00);
    frame_tick = 1'b1;
    edge_in = 4'b0110;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", ball_off_x, 32'd0);
    check("async_rst_y", ball_off_y, 32'd0);
    check("async_rst_in_play", {31'd0, in_play}, 32'd0);
    check("async_rst_scores", {24'd0, score_l, score_r}, 32'd0);
    frame_tick = 1'b0;
    edge_in = 4'hF;
    idle(1);
    check("rst_hold_x", ball_off_x, 32'd0);
    rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
